// File: rtl/ysyx_220066_mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states,
// RISC-V funct3 load/store encodings and the default bus watchdog limit.
package ysyx_220066_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arbState_t;

  localparam logic [2:0] MEMOP_B   = 3'b000;
  localparam logic [2:0] MEMOP_H   = 3'b001;
  localparam logic [2:0] MEMOP_W   = 3'b010;
  localparam logic [2:0] MEMOP_D   = 3'b011;
  localparam logic [2:0] MEMOP_BU  = 3'b100;
  localparam logic [2:0] MEMOP_HU  = 3'b101;
  localparam logic [2:0] MEMOP_WU  = 3'b110;
  localparam logic [2:0] MEMOP_BAD = 3'b111;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

  // An access is aligned when the low address bits below its size are zero.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [2:0] offset);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return offset[0];
      2'd2:    return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_220066_mem_arb_if.sv
// 64-bit single-outstanding memory bus between the arbiter (master) and memory (slave).
interface ysyx_220066_mem_arb_if;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_ack;
  logic [63:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
    input  bus_ack, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
    output bus_ack, bus_rdata, bus_err
  );
endinterface

// File: rtl/ysyx_220066_mem_arb_lsu_fmt.sv
// Combinational load extraction/extension and store lane replication/mask
// generation for one 8-byte bus word.
module ysyx_220066_lsu_fmt
  import ysyx_220066_pkg::*;
(
  input  logic [2:0]  i_memOp,
  input  logic [2:0]  i_offset,
  input  logic [63:0] i_rdata,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_loadData,
  output logic [63:0] o_storeData,
  output logic [7:0]  o_storeMask,
  output logic        o_error
);

  logic [63:0] w_shifted;
  logic [7:0]  w_baseMask;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_loadData = '0;
    case (i_memOp)
      MEMOP_B:  o_loadData = {{56{w_shifted[7]}},  w_shifted[7:0]};
      MEMOP_H:  o_loadData = {{48{w_shifted[15]}}, w_shifted[15:0]};
      MEMOP_W:  o_loadData = {{32{w_shifted[31]}}, w_shifted[31:0]};
      MEMOP_D:  o_loadData = w_shifted;
      MEMOP_BU: o_loadData = {56'd0, w_shifted[7:0]};
      MEMOP_HU: o_loadData = {48'd0, w_shifted[15:0]};
      MEMOP_WU: o_loadData = {32'd0, w_shifted[31:0]};
      default:  o_loadData = '0;
    endcase
  end

  // Replicating the store value into every lane lets the mask alone pick the bytes.
  always_comb begin
    o_storeData = i_wdata;
    w_baseMask  = 8'hFF;
    case (i_memOp[1:0])
      2'd0: begin o_storeData = {8{i_wdata[7:0]}};  w_baseMask = 8'h01; end
      2'd1: begin o_storeData = {4{i_wdata[15:0]}}; w_baseMask = 8'h03; end
      2'd2: begin o_storeData = {2{i_wdata[31:0]}}; w_baseMask = 8'h0F; end
      default: begin o_storeData = i_wdata;         w_baseMask = 8'hFF; end
    endcase
  end

  assign o_storeMask = w_baseMask << i_offset;
  assign o_error     = (i_memOp == MEMOP_BAD) | isMisaligned(i_memOp[1:0], i_offset);

endmodule

// File: rtl/ysyx_220066_mem_arb.sv
// Arbitrates instruction fetch and data load/store onto one memory bus, with a
// one-entry fetch buffer. Define YSYX_220066_ARB_TIMEOUT_EN to add a bus watchdog.
module ysyx_220066_mem_arb
  import ysyx_220066_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_rd,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        instr_error,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [2:0]  MemOp,
  input  logic [63:0] addr,
  input  logic [63:0] data_Wr,
  output logic [63:0] data_Rd,
  output logic        data_Rd_valid,
  output logic        data_Rd_error,
  ysyx_220066_mem_arb_if.master bus
);

  if (TIMEOUT == 0) begin : g_badTimeout
    $error("TIMEOUT must be at least 1");
  end

  arbState_t   r_state, w_nextState;
  logic        r_busReq, r_busWe;
  logic [63:0] r_busAddr, r_busWdata, r_fetchPc;
  logic [7:0]  r_busWmask;
  logic        r_bufValid, r_bufErr;
  logic [63:0] r_bufPc;
  logic [31:0] r_bufInstr;
  logic [63:0] r_dataRd;
  logic        r_dataErr;

  logic        w_issueFetch, w_issueData, w_dataReject;
  logic        w_dataReq, w_dataBad, w_fetchNeed, w_pcHit, w_pcMisaligned;
  logic        w_done, w_fault, w_timeout;
  logic [63:0] w_loadData, w_storeData;
  logic [7:0]  w_storeMask;
  logic        w_fmtError;
  logic [31:0] w_fetchWord;

  ysyx_220066_lsu_fmt u_lsuFmt (
    .i_memOp    (MemOp),
    .i_offset   (addr[2:0]),
    .i_rdata    (bus.bus_rdata),
    .i_wdata    (data_Wr),
    .o_loadData (w_loadData),
    .o_storeData(w_storeData),
    .o_storeMask(w_storeMask),
    .o_error    (w_fmtError)
  );

`ifdef YSYX_220066_ARB_TIMEOUT_EN
  logic [31:0] r_waitCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_waitCnt <= '0;
    else if (r_busReq && !w_done) r_waitCnt <= r_waitCnt + 32'd1;
    else                         r_waitCnt <= '0;
  end

  assign w_timeout = r_busReq && !bus.bus_ack && (r_waitCnt == TIMEOUT - 1);
`else
  assign w_timeout = 1'b0;
`endif

  // A watchdog expiry finishes the transaction exactly like an error ack.
  assign w_done  = r_busReq && (bus.bus_ack || w_timeout);
  assign w_fault = w_timeout ? 1'b1 : bus.bus_err;

  assign w_dataReq      = MemRd | MemWr;
  assign w_dataBad      = (MemRd & MemWr) | w_fmtError;
  assign w_pcMisaligned = |pc_rd[1:0];
  assign w_pcHit        = r_bufValid && (r_bufPc == pc_rd);
  assign w_fetchNeed    = !w_pcMisaligned && !w_pcHit;
  assign w_fetchWord    = r_fetchPc[2] ? bus.bus_rdata[63:32] : bus.bus_rdata[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_issueFetch = 1'b0;
    w_issueData  = 1'b0;
    w_dataReject = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dataReq) begin
          if (w_dataBad) begin
            w_dataReject = 1'b1;
            w_nextState  = RESP;
          end else begin
            w_issueData = 1'b1;
            w_nextState = DATA;
          end
        end else if (w_fetchNeed) begin
          w_issueFetch = 1'b1;
          w_nextState  = FETCH;
        end
      end
      FETCH:   if (w_done) w_nextState = IDLE;
      DATA:    if (w_done) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busReq   <= 1'b0;
      r_busWe    <= 1'b0;
      r_busAddr  <= '0;
      r_busWdata <= '0;
      r_busWmask <= '0;
      r_fetchPc  <= '0;
    end else if (w_issueData) begin
      r_busReq   <= 1'b1;
      r_busWe    <= MemWr;
      r_busAddr  <= {addr[63:3], 3'b000};
      r_busWdata <= MemWr ? w_storeData : '0;
      r_busWmask <= MemWr ? w_storeMask : '0;
    end else if (w_issueFetch) begin
      r_busReq   <= 1'b1;
      r_busWe    <= 1'b0;
      r_busAddr  <= {pc_rd[63:3], 3'b000};
      r_busWdata <= '0;
      r_busWmask <= '0;
      r_fetchPc  <= pc_rd;
    end else if (w_done) begin
      r_busReq   <= 1'b0;
    end
  end

  // The buffer fills even if pc_rd has moved on; the hit compare sorts it out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bufValid <= 1'b0;
      r_bufErr   <= 1'b0;
      r_bufPc    <= '0;
      r_bufInstr <= '0;
    end else if (r_state == FETCH && w_done) begin
      r_bufValid <= 1'b1;
      r_bufErr   <= w_fault;
      r_bufPc    <= r_fetchPc;
      r_bufInstr <= w_fault ? 32'd0 : w_fetchWord;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dataRd  <= '0;
      r_dataErr <= 1'b0;
    end else if (w_dataReject) begin
      r_dataRd  <= '0;
      r_dataErr <= 1'b1;
    end else if (r_state == DATA && w_done) begin
      r_dataRd  <= (w_fault || MemWr) ? 64'd0 : w_loadData;
      r_dataErr <= w_fault;
    end
  end

  assign instr         = w_pcMisaligned ? 32'd0 : r_bufInstr;
  assign instr_valid   = w_pcMisaligned | w_pcHit;
  assign instr_error   = w_pcMisaligned | (w_pcHit & r_bufErr);
  assign data_Rd       = r_dataRd;
  assign data_Rd_valid = (r_state == RESP);
  assign data_Rd_error = r_dataErr;

  assign bus.bus_req   = r_busReq;
  assign bus.bus_we    = r_busWe;
  assign bus.bus_addr  = r_busAddr;
  assign bus.bus_wdata = r_busWdata;
  assign bus.bus_wmask = r_busWmask;

endmodule

// File: tb/tb_ysyx_220066_mem_arb.sv
// Scoreboard bench for ysyx_220066_mem_arb: expected bus transactions and data
// responses are queued by the stimulus and popped by independent monitors.
module tb_ysyx_220066_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pc_rd;
  logic [31:0] instr;
  logic        instr_valid, instr_error;
  logic        MemRd, MemWr;
  logic [2:0]  MemOp;
  logic [63:0] addr, data_Wr, data_Rd;
  logic        data_Rd_valid, data_Rd_error;

  logic        slaveEnable, slaveErr, slaveAck, strayAck;
  logic [63:0] slaveRdata;
  int          slaveDelay, slaveCnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } busExp_t;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } dataExp_t;

  busExp_t  busQ[$];
  dataExp_t dataQ[$];
  busExp_t  curBus;
  dataExp_t curData;
  logic     prevReq = 1'b0;

  ysyx_220066_mem_arb_if bus ();

  assign bus.bus_ack   = slaveAck | strayAck;
  assign bus.bus_rdata = slaveRdata;
  assign bus.bus_err   = slaveErr;

  ysyx_220066_mem_arb #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_rd        (pc_rd),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_error  (instr_error),
    .MemRd        (MemRd),
    .MemWr        (MemWr),
    .MemOp        (MemOp),
    .addr         (addr),
    .data_Wr      (data_Wr),
    .data_Rd      (data_Rd),
    .data_Rd_valid(data_Rd_valid),
    .data_Rd_error(data_Rd_error),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectBus(input logic we, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] m);
    busQ.push_back('{we: we, addr: a, wdata: wd, wmask: m});
  endtask

  task automatic waitInstr(input string name, input int maxCycles);
    bit seen = 0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: instr_valid never rose within %0d cycles", name, maxCycles);
    end
  endtask

  // Drives one core data request and holds it until the completion pulse.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] op,
                               input logic [63:0] a, input logic [63:0] wd,
                               input logic [63:0] expData, input logic expErr, input int expLat);
    int lat = 0;
    bit seen = 0;
    dataQ.push_back('{data: expData, err: expErr});
    MemRd = rd; MemWr = wr; MemOp = op; addr = a; data_Wr = wd;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (data_Rd_valid) begin
        lat  = i;
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL dataTimeout: no data_Rd_valid for addr 0x%0h", a);
    end else if (expLat > 0) begin
      checkOutput("dataLatency", 64'(lat), 64'(expLat));
    end
    step();
    MemRd = 1'b0;
    MemWr = 1'b0;
  endtask

  // Memory model: acks slaveDelay cycles after a request appears.
  always @(posedge clk) begin
    #1;
    if (rst || !bus.bus_req || !slaveEnable || slaveAck) begin
      slaveAck = 1'b0;
      slaveCnt = 0;
    end else if (slaveCnt == slaveDelay) begin
      slaveAck = 1'b1;
    end else begin
      slaveCnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bus_req && !prevReq) begin
        if (busQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedBus: request at 0x%0h with no expected transaction", bus.bus_addr);
        end else begin
          curBus = busQ.pop_front();
          checkOutput("busWe",    64'(bus.bus_we),    64'(curBus.we));
          checkOutput("busAddr",  bus.bus_addr,       curBus.addr);
          checkOutput("busWdata", bus.bus_wdata,      curBus.wdata);
          checkOutput("busWmask", 64'(bus.bus_wmask), 64'(curBus.wmask));
        end
      end
      if (bus.bus_req && bus.bus_ack) begin
        checkOutput("busHoldAddr",  bus.bus_addr,       curBus.addr);
        checkOutput("busHoldWmask", 64'(bus.bus_wmask), 64'(curBus.wmask));
      end
    end
    prevReq = bus.bus_req;
  end

  always @(negedge clk) begin
    if (!rst && data_Rd_valid) begin
      if (dataQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedResp: data_Rd_valid with data 0x%0h and no expected response", data_Rd);
      end else begin
        curData = dataQ.pop_front();
        checkOutput("dataRd",    data_Rd,             curData.data);
        checkOutput("dataRdErr", 64'(data_Rd_error),  64'(curData.err));
      end
    end
  end

  initial begin
    #1;
    rst = 1'b1;
    pc_rd = 64'h8000_0004;
    MemRd = 1'b0; MemWr = 1'b0; MemOp = 3'b000; addr = '0; data_Wr = '0;
    slaveEnable = 1'b1; slaveDelay = 2; slaveCnt = 0; slaveAck = 1'b0; strayAck = 1'b0;
    slaveErr = 1'b0; slaveRdata = 64'h1122_3344_5566_7788;

    @(negedge clk);
    checkOutput("rstBusReq",    64'(bus.bus_req),     64'd0);
    checkOutput("rstInstr",     64'(instr),           64'd0);
    checkOutput("rstInstrVal",  64'(instr_valid),     64'd0);
    checkOutput("rstDataValid", 64'(data_Rd_valid),   64'd0);
    checkOutput("rstDataErr",   64'(data_Rd_error),   64'd0);
    checkOutput("rstDataRd",    data_Rd,              64'd0);

    $display("[TB] fetch with upper-word select");
    expectBus(1'b0, 64'h8000_0000, 64'd0, 8'h00);
    step();
    rst = 1'b0;
    waitInstr("fetch1", 20);
    checkOutput("instr1",    64'(instr),       64'h1122_3344);
    checkOutput("instrErr1", 64'(instr_error), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("instrHeld", 64'(instr_valid), 64'd1);

    $display("[TB] data load behind pending fetch");
    step();
    slaveRdata = 64'hA5A5_A5A5_8012_3456;
    pc_rd = 64'h8000_0010;
    expectBus(1'b0, 64'h8000_0010, 64'd0, 8'h00);
    step();
    expectBus(1'b0, 64'h8000_1000, 64'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h8000_1003, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 0);
    checkOutput("instr2",      64'(instr),       64'h8012_3456);
    checkOutput("instrValid2", 64'(instr_valid), 64'd1);

    $display("[TB] stores");
    expectBus(1'b1, 64'h8000_1000, 64'hBEEF_BEEF_BEEF_BEEF, 8'hC0);
    applyStimulus(1'b0, 1'b1, 3'b001, 64'h8000_1006, 64'h0000_0000_0000_BEEF, 64'd0, 1'b0, 0);
    expectBus(1'b1, 64'h8000_1000, 64'hABAB_ABAB_ABAB_ABAB, 8'h20);
    applyStimulus(1'b0, 1'b1, 3'b000, 64'h8000_1005, 64'h0000_0012_3456_78AB, 64'd0, 1'b0, 0);
    expectBus(1'b1, 64'h8000_1000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hF0);
    applyStimulus(1'b0, 1'b1, 3'b010, 64'h8000_1004, 64'h0000_0000_DEAD_BEEF, 64'd0, 1'b0, 0);
    expectBus(1'b1, 64'h8000_1000, 64'h0123_4567_89AB_CDEF, 8'hFF);
    applyStimulus(1'b0, 1'b1, 3'b011, 64'h8000_1000, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 0);

    $display("[TB] loads with extension");
    expectBus(1'b0, 64'h8000_1000, 64'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'b001, 64'h8000_1006, 64'd0, 64'hFFFF_FFFF_FFFF_A5A5, 1'b0, 5);
    expectBus(1'b0, 64'h8000_1000, 64'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'b100, 64'h8000_1003, 64'd0, 64'h0000_0000_0000_0080, 1'b0, 0);
    expectBus(1'b0, 64'h8000_1000, 64'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'b101, 64'h8000_1002, 64'd0, 64'h0000_0000_0000_8012, 1'b0, 0);
    expectBus(1'b0, 64'h8000_1000, 64'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'b010, 64'h8000_1000, 64'd0, 64'hFFFF_FFFF_8012_3456, 1'b0, 0);
    expectBus(1'b0, 64'h8000_1000, 64'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'b110, 64'h8000_1004, 64'd0, 64'h0000_0000_A5A5_A5A5, 1'b0, 0);
    expectBus(1'b0, 64'h8000_1000, 64'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'b011, 64'h8000_1000, 64'd0, 64'hA5A5_A5A5_8012_3456, 1'b0, 0);
    expectBus(1'b0, 64'h8000_1000, 64'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h8000_1001, 64'd0, 64'h0000_0000_0000_0034, 1'b0, 0);

    $display("[TB] rejected requests skip the bus");
    applyStimulus(1'b1, 1'b0, 3'b010, 64'h8000_1002, 64'd0, 64'd0, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 3'b011, 64'h8000_1000, 64'd0, 64'd0, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 3'b111, 64'h8000_1000, 64'd0, 64'd0, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 3'b011, 64'h8000_1004, 64'd5, 64'd0, 1'b1, 2);

    $display("[TB] bus error on load");
    slaveErr = 1'b1;
    expectBus(1'b0, 64'h8000_1008, 64'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'b011, 64'h8000_1008, 64'd0, 64'd0, 1'b1, 0);
    slaveErr = 1'b0;

    $display("[TB] pc change during fetch");
    slaveDelay = 4;
    pc_rd = 64'h100;
    expectBus(1'b0, 64'h100, 64'd0, 8'h00);
    #1;
    checkOutput("pcChangeDrop", 64'(instr_valid), 64'd0);
    step();
    step();
    pc_rd = 64'h200;
    expectBus(1'b0, 64'h200, 64'd0, 8'h00);
    repeat (5) @(negedge clk);
    checkOutput("staleFill", 64'(instr_valid), 64'd0);
    waitInstr("fetch200", 30);
    checkOutput("instr200", 64'(instr), 64'h8012_3456);

    $display("[TB] misaligned pc and fetch error");
    step();
    pc_rd = 64'h202;
    #1;
    checkOutput("pcMisValid", 64'(instr_valid), 64'd1);
    checkOutput("pcMisErr",   64'(instr_error), 64'd1);
    checkOutput("pcMisInstr", 64'(instr),       64'd0);
    repeat (3) step();
    slaveDelay = 1;
    slaveErr = 1'b1;
    pc_rd = 64'h300;
    expectBus(1'b0, 64'h300, 64'd0, 8'h00);
    waitInstr("fetch300", 20);
    checkOutput("fetchErr", 64'(instr_error), 64'd1);
    step();
    slaveErr = 1'b0;

    $display("[TB] reset mid-transaction and stray ack");
    slaveDelay = 10;
    pc_rd = 64'h400;
    expectBus(1'b0, 64'h400, 64'd0, 8'h00);
    repeat (3) step();
    rst = 1'b1;
    #1;
    checkOutput("rstMidReq",   64'(bus.bus_req), 64'd0);
    checkOutput("rstMidValid", 64'(instr_valid), 64'd0);
    pc_rd = 64'h402;
    step();
    step();
    rst = 1'b0;
    step();
    slaveRdata = 64'hCAFE_F00D_1234_5678;
    strayAck = 1'b1;
    step();
    strayAck = 1'b0;
    slaveDelay = 2;
    pc_rd = 64'h400;
    expectBus(1'b0, 64'h400, 64'd0, 8'h00);
    waitInstr("fetch400", 20);
    checkOutput("instr400",    64'(instr),       64'h1234_5678);
    checkOutput("instrErr400", 64'(instr_error), 64'd0);

`ifdef YSYX_220066_ARB_TIMEOUT_EN
    $display("[TB] watchdog expiry and reset during wait");
    begin
      int reqCycles = 0;
      step();
      slaveEnable = 1'b0;
      pc_rd = 64'h500;
      expectBus(1'b0, 64'h500, 64'd0, 8'h00);
      step();
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (bus.bus_req) reqCycles++;
        else break;
      end
      checkOutput("timeoutCycles", 64'(reqCycles),   64'd4);
      checkOutput("timeoutValid",  64'(instr_valid), 64'd1);
      checkOutput("timeoutErr",    64'(instr_error), 64'd1);
      step();
      pc_rd = 64'h600;
      expectBus(1'b0, 64'h600, 64'd0, 8'h00);
      step();
      step();
      rst = 1'b1;
      #1;
      checkOutput("timeoutRstReq", 64'(bus.bus_req), 64'd0);
      pc_rd = 64'h602;
      step();
      rst = 1'b0;
      slaveEnable = 1'b1;
    end
`endif

    step();
    repeat (3) @(negedge clk);
    checkOutput("busQEmpty",  64'(busQ.size()),  64'd0);
    checkOutput("dataQEmpty", 64'(dataQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/ysyx_220066_mem_arb.md
YSYX_220066_MEM_ARB -- requirements
Module: ysyx_220066_mem_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max bus wait cycles (used only with watchdog compiled in).
REQ-002 SHALL have ports clk input 1 clock; rst input 1 reset, asynchronous, active-high.
REQ-003 SHALL have ports pc_rd input 64 fetch address; instr output 32 fetched word; instr_valid output 1 instr matches pc_rd; instr_error output 1 fetch fault.
REQ-004 SHALL have ports MemRd input 1, MemWr input 1, MemOp input 3 (funct3 encoding), addr input 64, data_Wr input 64: core data request, held until completion.
REQ-005 SHALL have ports data_Rd output 64 extended load data; data_Rd_valid output 1 one-cycle completion pulse (loads and stores); data_Rd_error output 1 fault, qualified by data_Rd_valid.
REQ-006 SHALL have ports bus_req output 1, bus_we output 1, bus_addr output 64 (8-byte aligned), bus_wdata output 64, bus_wmask output 8, bus_ack input 1, bus_rdata input 64, bus_err input 1.

Function
REQ-007 SHALL use FSM states IDLE, FETCH, DATA, RESP; one bus transaction outstanding at most.
REQ-008 In IDLE, a data request (MemRd|MemWr) SHALL win over fetch; fetch issues only when the buffer does not hold pc_rd.
REQ-009 bus_req and bus_addr/we/wdata/wmask SHALL stay constant from issue until the bus_ack cycle.
REQ-010 On bus_ack in FETCH, SHALL store pc and bus_rdata[pc[2]*32 +: 32] into a one-entry buffer, set buf_valid, return to IDLE.
REQ-011 instr_valid SHALL equal buf_valid && buf_pc==pc_rd, combinationally; a pc_rd change drops it in the same cycle.
REQ-012 A fetch completing for a pc no longer equal to pc_rd SHALL still fill the buffer; a new fetch for current pc_rd issues next IDLE cycle.
REQ-013 pc_rd[1:0]!=0 SHALL give instr_valid=1, instr_error=1, instr=0 without a bus access.
REQ-014 On bus_ack in DATA, SHALL go to RESP, pulse data_Rd_valid for one cycle, then IDLE; request is not re-accepted in RESP.
REQ-015 Loads SHALL shift bus_rdata by addr[2:0] bytes and sign-extend (MemOp 000/001/010) or zero-extend (100/101/110); 011 returns full 64 bits.
REQ-016 Stores SHALL replicate data_Wr into the addressed lanes; wmask = 1/3/15/255 for MemOp[1:0]=0/1/2/3, shifted by addr[2:0].
REQ-017 Misaligned data access (addr not multiple of 2^MemOp[1:0]) or MemOp 111 SHALL skip the bus and pulse data_Rd_valid with data_Rd_error=1 one cycle later.
REQ-018 bus_err with bus_ack SHALL set instr_error (fetch, buffered) or data_Rd_error (data); data_Rd=0 on error.
REQ-019 MemRd and MemWr both high SHALL be treated as an error per REQ-017.

Reset
REQ-020 Asserting rst SHALL immediately force IDLE, buf_valid=0, bus_req=0, data_Rd_valid=0, data_Rd_error=0, instr=0, data_Rd=0, wait counter=0.
REQ-021 rst mid-transaction SHALL abandon it; a later bus_ack with bus_req low SHALL be ignored.

Configuration
REQ-022 With YSYX_220066_ARB_TIMEOUT_EN defined, a counter SHALL count bus_req-high cycles and, on reaching TIMEOUT with no ack, end the transaction as if bus_err were returned.
REQ-023 Without YSYX_220066_ARB_TIMEOUT_EN, no counter SHALL exist; transactions wait indefinitely.

Structure
REQ-024 Package ysyx_220066_pkg SHALL hold the FSM state enum, MemOp encodings, and TIMEOUT default.
REQ-025 Load extraction/extension and store mask/lane generation SHALL live in combinational sub-module ysyx_220066_lsu_fmt.

Verification
REQ-026 pc_rd=0x80000004, bus_rdata=0x11223344_55667788 ack after 2 cycles -> instr=0x11223344, instr_valid=1 while pc_rd held.
REQ-027 Fetch pending, MemRd=1 MemOp=000 addr=0x80001003, bus_rdata byte3=0x80 -> data serviced after fetch ack, data_Rd=0xFFFFFFFF_FFFFFF80, single data_Rd_valid pulse.
REQ-028 MemWr=1 MemOp=001 addr=0x80001006 data_Wr=0xBEEF -> bus_wmask=0xC0, bus_wdata[63:48]=0xBEEF, bus_we=1.
REQ-029 MemRd=1 MemOp=010 addr=0x80001002 -> no bus_req, data_Rd_valid=1 with data_Rd_error=1 next cycle.
REQ-030 pc_rd changes 0x100->0x200 mid-fetch -> instr_valid stays 0, second fetch at 0x200 issues, instr_valid rises on its ack.
REQ-031 With YSYX_220066_ARB_TIMEOUT_EN, TIMEOUT=4, no bus_ack -> bus_req drops after 4 cycles, instr_error=1; rst asserted mid-wait -> bus_req=0 same cycle.
